i2s_tx: RTL and testbench

//  Stereo I2S transmitter feeding the SGTL5000 DAC input (codec in I2S slave mode).

---
 rtl/i2s_pkg.sv | 21 ++
 rtl/i2s_sample_fifo.sv | 58 +++++
 rtl/i2s_tx.sv | 128 ++++++++++++
 tb/tb_i2s_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants and types for the I2S transmitter.
//   CTR_W      width of the frame divider (1024 system clocks per frame)
//   MCLK_BIT   divider bit driving MCLK  (Clk/4)
//   BCLK_BIT   divider bit driving BCLK  (Clk/16)
//   LRCLK_BIT  divider bit driving LRCLK (Clk/1024)
//   SLOT_BITS  BCLK slots per channel half-frame
//   stereo_t   one left/right sample pair at the default 16-bit width
package i2s_pkg;

    localparam int CTR_W     = 10;
    localparam int MCLK_BIT  = 1;
    localparam int BCLK_BIT  = 3;
    localparam int LRCLK_BIT = 9;
    localparam int SLOT_BITS = 32;

    typedef struct packed {
        logic signed [15:0] left;
        logic signed [15:0] right;
    } stereo_t;

endpackage

// File: rtl/i2s_sample_fifo.sv
// i2s_sample_fifo: synchronous FIFO for stereo pairs.
// Ports:
//   Clk, Reset   system clock, synchronous active-high reset
//   push, wdata  write request and data (ignored when full)
//   pop, rdata   read request (ignored when empty); rdata shows the head entry
//   full, empty  status flags
//   level        number of stored entries, 0..DEPTH
module i2s_sample_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: stereo I2S transmitter for the SGTL5000 DAC input (codec is I2S slave).
// One 10-bit divider on the 50 MHz clock produces MCLK/BCLK/LRCLK; each
// 1024-cycle frame carries one buffered stereo pair, MSB first, one BCLK
// after the LRCLK transition.
// Ports:
//   Clk           50 MHz system clock
//   Reset         synchronous, active-high
//   en            1 = run divider and serial clocks, 0 = hold divider at 0
//   s_valid/s_ready/s_left/s_right   producer handshake for one stereo pair
//   fifo_level    pairs currently buffered
//   mclk, bclk, lrclk, dout          codec pins (lrclk 0 = left)
//   underrun      1-cycle pulse when a frame starts with the FIFO empty
//   underrun_cnt  saturating underrun count; present only when
//                 I2S_TX_UNDERRUN_CNT_EN is defined
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   en,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DW-1:0]          s_left,
    input  logic [DW-1:0]          s_right,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   mclk,
    output logic                   bclk,
    output logic                   lrclk,
    output logic                   dout,
    output logic                   underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]            underrun_cnt
`endif
);

    logic [CTR_W-1:0]     ctr;
    logic [CTR_W-1:0]     ctr_next;
    logic [DW-1:0]        hold_l;
    logic [DW-1:0]        hold_r;
    logic [2*DW-1:0]      fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 frame_edge;
    logic [4:0]           slot_k;
    logic [DW-1:0]        word;
    logic [SLOT_BITS-1:0] slot_vec;
    logic                 next_bit;

    assign s_ready    = !fifo_full && !Reset;
    assign push       = s_valid && s_ready;
    assign frame_edge = en && (ctr == '1);
    assign ctr_next   = en ? ctr + CTR_W'(1) : '0;

    i2s_sample_fifo #(
        .W     (2*DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (push),
        .wdata ({s_left, s_right}),
        .pop   (frame_edge),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // dout is launched with the divider value it will accompany, so the bit
    // is selected from ctr_next. Slot vector: bit 31 is slot 0 (always 0),
    // the sample sits right below it, trailing slots pad with zeros.
    always_comb begin
        slot_k             = ctr_next[LRCLK_BIT-1:BCLK_BIT+1];
        word               = ctr_next[LRCLK_BIT] ? hold_r : hold_l;
        slot_vec           = '0;
        slot_vec[30 -: DW] = word;
        next_bit           = slot_vec[~slot_k];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ctr      <= '0;
            mclk     <= 1'b0;
            bclk     <= 1'b0;
            lrclk    <= 1'b0;
            dout     <= 1'b0;
            underrun <= 1'b0;
            hold_l   <= '0;
            hold_r   <= '0;
        end else begin
            ctr      <= ctr_next;
            // Registered from ctr_next so each clock pin equals its divider bit.
            mclk     <= ctr_next[MCLK_BIT];
            bclk     <= ctr_next[BCLK_BIT];
            lrclk    <= ctr_next[LRCLK_BIT];
            underrun <= frame_edge && fifo_empty;
            if (frame_edge) begin
                if (fifo_empty) begin
                    hold_l <= '0;
                    hold_r <= '0;
                end else begin
                    hold_l <= fifo_rdata[2*DW-1:DW];
                    hold_r <= fifo_rdata[DW-1:0];
                end
            end
            // Change data together with the BCLK falling edge.
            if (!en)
                dout <= 1'b0;
            else if (ctr[BCLK_BIT:0] == '1)
                dout <= next_bit;
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    always_ff @(posedge Clk) begin
        if (Reset)
            underrun_cnt <= '0;
        else if (underrun && (underrun_cnt != 16'hFFFF))
            underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;
    import i2s_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        en;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_left;
    logic [15:0] s_right;
    logic [3:0]  fifo_level;
    logic        mclk, bclk, lrclk, dout, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    i2s_tx #(.DW(16), .DEPTH(8)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .en         (en),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_left     (s_left),
        .s_right    (s_right),
        .fifo_level (fifo_level),
        .mclk       (mclk),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .dout       (dout),
        .underrun   (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: divider, pair scoreboard and playing-frame queue.
    logic [9:0]  tb_ctr = '0;
    logic        en_d;
    logic        exp_und;
    stereo_t     exp_q[$];
    stereo_t     frame_q[$];
    logic [31:0] cap_l, cap_r;
    bit          cap_ok = 0;
    bit          mon_on = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slot_vec(input logic [15:0] w);
        return {1'b0, w, 15'b0};
    endfunction

    always @(posedge Clk) begin
        en_d    <= en;
        exp_und <= !Reset && en && (tb_ctr == 10'd1023) && (exp_q.size() == 0);
        if (Reset) begin
            exp_q.delete();
            frame_q.delete();
            frame_q.push_back('0);
        end else if (en && tb_ctr == 10'd1023) begin
            if (exp_q.size() > 0) frame_q.push_back(exp_q.pop_front());
            else                  frame_q.push_back('0);
        end
        tb_ctr <= (Reset || !en) ? 10'd0 : tb_ctr + 10'd1;
    end

    always @(negedge Clk) begin
        if (mon_on) begin
            check("mclk", mclk, tb_ctr[1]);
            check("bclk", bclk, tb_ctr[3]);
            check("lrclk", lrclk, tb_ctr[9]);
            check("underrun", underrun, exp_und);
            if (!en_d) check("dout_idle", dout, 0);
            if (Reset || !en) begin
                cap_ok = 0;
            end else begin
                if (tb_ctr == 10'd0) cap_ok = 1;
                if (tb_ctr[3:0] == 4'd8) begin
                    if (tb_ctr[9]) cap_r[5'd31 - tb_ctr[8:4]] = dout;
                    else           cap_l[5'd31 - tb_ctr[8:4]] = dout;
                end
                if (tb_ctr == 10'd1023) begin
                    if (frame_q.size() == 0) begin
                        check("frame_q_nonempty", 0, 1);
                    end else begin
                        stereo_t f;
                        f = frame_q.pop_front();
                        if (cap_ok) begin
                            check("left_frame", cap_l, slot_vec(f.left));
                            check("right_frame", cap_r, slot_vec(f.right));
                        end
                    end
                end
            end
        end
    end

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        bit ok;
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        ok = s_ready;
        @(posedge Clk);
        @(negedge Clk);
        s_valid = 1'b0;
        if (ok) exp_q.push_back('{left: l, right: r});
    endtask

    task automatic wait_ctr(input int v);
        for (int i = 0; i < 2100; i++) begin
            @(negedge Clk);
            if (tb_ctr == 10'(v)) return;
        end
        check("wait_ctr_timeout", 0, 1);
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return mclk;
            1:       return bclk;
            default: return lrclk;
        endcase
    endfunction

    task automatic measure(input string tag, input int which, input int exp_p);
        int   t0;
        logic prev, cur;
        t0   = -1;
        prev = sig(which);
        for (int n = 0; n < 3000; n++) begin
            @(negedge Clk);
            cur = sig(which);
            if (cur && !prev) begin
                if (t0 >= 0) begin
                    check(tag, n - t0, exp_p);
                    return;
                end
                t0 = n;
            end
            prev = cur;
        end
        check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int pulses;
        int acc_ctr;
        bit done;

        Reset = 1'b1; en = 1'b1; s_valid = 1'b0; s_left = '0; s_right = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_clks", {mclk, bclk, lrclk, dout, underrun}, 5'b0);
        check("rst_level", fifo_level, 0);
        check("rst_ready", s_ready, 0);
        mon_on = 1;
        Reset  = 1'b0;

        // Free-running clocks with no data.
        measure("mclk_period", 0, 4);
        measure("bclk_period", 1, 16);
        measure("lrclk_period", 2, 1024);
        pulses = 0;
        repeat (1024) begin
            @(negedge Clk);
            pulses += int'(underrun);
        end
        check("underrun_per_frame", pulses, 1);

        // Two directed patterns, including sign/magnitude extremes.
        wait_ctr(100);
        push_pair(16'hA5C3, 16'h0F0F);
        wait_ctr(0);
        check("no_underrun_data", underrun, 0);
        wait_ctr(100);
        push_pair(16'h8000, 16'h7FFF);
        wait_ctr(1023);

        // Fill to full, then ninth pair waits for the frame pop.
        wait_ctr(10);
        for (int i = 0; i < 8; i++) push_pair(16'(16'h1000 + i), 16'(16'hF000 - i));
        check("full_level", fifo_level, 8);
        check("full_ready", s_ready, 0);
        s_valid = 1'b1; s_left = 16'h0109; s_right = 16'hFEF7;
        acc_ctr = -1;
        for (int i = 0; i < 2100 && acc_ctr < 0; i++) begin
            if (s_ready) acc_ctr = int'(tb_ctr);
            else @(negedge Clk);
        end
        @(posedge Clk);
        @(negedge Clk);
        s_valid = 1'b0;
        if (acc_ctr >= 0) exp_q.push_back('{left: 16'h0109, right: 16'hFEF7});
        check("ninth_accept_ctr", acc_ctr, 0);
        check("ninth_level", fifo_level, 8);
        done = 0;
        for (int i = 0; i < 12000 && !done; i++) begin
            @(negedge Clk);
            done = (fifo_level == 0);
        end
        check("drain_done", done, 1);

        // Push on the pop edge with one pair stored.
        wait_ctr(500);
        push_pair(16'h1234, 16'h5678);
        wait_ctr(1023);
        push_pair(16'h9ABC, 16'hDEF0);
        check("pushpop_level", fifo_level, 1);
        check("pushpop_no_underrun", underrun, 0);

        // Push on the pop edge into an empty FIFO.
        wait_ctr(1023);
        wait_ctr(1023);
        push_pair(16'h0001, 16'h8001);
        check("empty_push_underrun", underrun, 1);
        check("empty_push_level", fifo_level, 1);

        // Reset mid-frame while a real sample is playing.
        wait_ctr(100);
        push_pair(16'h3C3C, 16'hC3C3);
        wait_ctr(1023);
        wait_ctr(300);
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check("midrst_clks", {mclk, bclk, lrclk, dout}, 4'b0);
        check("midrst_level", fifo_level, 0);
        @(negedge Clk);

        // Divider held while disabled; FIFO still accepts.
        Reset = 1'b0;
        en    = 1'b0;
        repeat (20) @(negedge Clk);
        push_pair(16'h6A6A, 16'h9595);
        repeat (30) @(negedge Clk);
        check("en0_clks", {mclk, bclk, lrclk, dout, underrun}, 5'b0);
        check("en0_level", fifo_level, 1);
        en = 1'b1;
        wait_ctr(1023);
        wait_ctr(1023);
        wait_ctr(1023);

`ifdef I2S_TX_UNDERRUN_CNT_EN
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        wait_ctr(1023);
        wait_ctr(1023);
        wait_ctr(1023);
        @(negedge Clk);
        check("underrun_cnt", underrun_cnt, 3);
`endif

        mon_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
